// File: rtl/telemetry_framer.sv
// Telemetry packetiser: snapshots NUM_CH status channels and streams a framed,
// sequence-numbered, XOR-checksummed byte frame over a valid/ready byte port.
module telemetry_framer #(
    parameter int          NUM_CH        = 4,
    parameter int          CH_W          = 8,
    parameter int          PERIOD_CYCLES = 1_000_000,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*CH_W-1:0]   ch_data,
    input  logic                     enable,
    input  logic                     send_now,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun,
    output logic [2:0]               dbg_state
);
    localparam int BPC = (CH_W + 7) / 8;
    localparam int LEN = NUM_CH * BPC;
    localparam int IW  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int TW  = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [TW-1:0] TERM     = TW'((PERIOD_CYCLES > 0) ? PERIOD_CYCLES - 1 : 0);
    localparam logic [7:0]    LEN_BYTE = 8'(LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_SEQ, S_LEN, S_PAYLOAD, S_CSUM
    } state_t;

    // Handshake: a byte transfers on any cycle where tx_valid and tx_ready are
    // both high; tx_valid and tx_data only change after such a transfer.
    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              csum_q, csum_d;
    logic                    pending_q, pending_d;
    logic [NUM_CH*CH_W-1:0]  snap_q;
    logic                    snap_load;
    logic                    frame_done_d, overrun_d;
    logic [TW-1:0]           timer_q;
    logic                    tick, trig, accept;
    logic [7:0]              pay_mem [LEN];

    assign tick = (PERIOD_CYCLES > 0) && enable && (timer_q == TERM);
    assign trig = send_now | tick;

    always_ff @(posedge clk) begin
        if (rst || !enable || tick || PERIOD_CYCLES == 0)
            timer_q <= '0;
        else
            timer_q <= timer_q + 1'b1;
    end

    // Each channel is zero-extended to BPC bytes, most significant byte first.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [15:0] ext;
        assign ext = 16'(snap_q[k*CH_W +: CH_W]);
        if (BPC == 2) begin : g_two
            assign pay_mem[2*k]   = ext[15:8];
            assign pay_mem[2*k+1] = ext[7:0];
        end else begin : g_one
            assign pay_mem[k] = ext[7:0];
        end
    end

    assign tx_valid  = (state_q != S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = tx_valid & tx_ready;
    assign dbg_state = state_q;

    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            S_SYNC:    tx_data = SYNC_BYTE;
            S_SEQ:     tx_data = seq_q;
            S_LEN:     tx_data = LEN_BYTE;
            S_PAYLOAD: tx_data = pay_mem[idx_q];
            S_CSUM:    tx_data = csum_q;
            default:   tx_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        seq_d        = seq_q;
        csum_d       = csum_q;
        pending_d    = pending_q;
        snap_load    = 1'b0;
        frame_done_d = 1'b0;
        overrun_d    = 1'b0;
        case (state_q)
            S_IDLE: if (trig) begin
                state_d   = S_SYNC;
                snap_load = 1'b1;
                csum_d    = 8'h00;
            end
            S_SYNC: if (accept) state_d = S_SEQ;
            S_SEQ: if (accept) begin
                state_d = S_LEN;
                csum_d  = csum_q ^ tx_data;
            end
            S_LEN: if (accept) begin
                state_d = S_PAYLOAD;
                idx_d   = '0;
                csum_d  = csum_q ^ tx_data;
            end
            S_PAYLOAD: if (accept) begin
                csum_d = csum_q ^ tx_data;
                if (idx_q == LAST_IDX) state_d = S_CSUM;
                else                   idx_d   = idx_q + 1'b1;
            end
            S_CSUM: if (accept) begin
                frame_done_d = 1'b1;
                seq_d        = seq_q + 8'd1;
                if (pending_q || trig) begin
                    // Chain straight into the next frame with no idle cycle.
                    state_d   = S_SYNC;
                    snap_load = 1'b1;
                    csum_d    = 8'h00;
                    pending_d = 1'b0;
                    overrun_d = pending_q && trig;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Triggers during a frame (other than the chaining CSUM cycle) queue one deep.
        if (trig && state_q != S_IDLE && !(state_q == S_CSUM && accept)) begin
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            seq_q      <= 8'h00;
            csum_q     <= 8'h00;
            pending_q  <= 1'b0;
            snap_q     <= '0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            seq_q      <= seq_d;
            csum_q     <= csum_d;
            pending_q  <= pending_d;
            frame_done <= frame_done_d;
            overrun    <= overrun_d;
            if (snap_load) snap_q <= ch_data;
        end
    end
endmodule

// File: tb/tb_telemetry_framer.sv
// Directed bench for telemetry_framer: three instances cover the 8-bit and
// 12-bit channel layouts and the periodic trigger.
module tb_telemetry_framer;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0] ch_data_a;
    logic        enable_a, send_now_a, tx_ready_a;
    logic [7:0]  tx_data_a;
    logic        tx_valid_a, busy_a, frame_done_a, overrun_a;
    logic [2:0]  dbg_state_a;

    logic [23:0] ch_data_b;
    logic        enable_b, send_now_b, tx_ready_b;
    logic [7:0]  tx_data_b;
    logic        tx_valid_b, busy_b, frame_done_b, overrun_b;
    logic [2:0]  dbg_state_b;

    logic [31:0] ch_data_c;
    logic        enable_c, send_now_c, tx_ready_c;
    logic [7:0]  tx_data_c;
    logic        tx_valid_c, busy_c, frame_done_c, overrun_c;
    logic [2:0]  dbg_state_c;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    telemetry_framer #(.NUM_CH(4), .CH_W(8), .PERIOD_CYCLES(0), .SYNC_BYTE(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .ch_data(ch_data_a), .enable(enable_a), .send_now(send_now_a),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .busy(busy_a),
        .frame_done(frame_done_a), .overrun(overrun_a), .dbg_state(dbg_state_a));

    telemetry_framer #(.NUM_CH(2), .CH_W(12), .PERIOD_CYCLES(0), .SYNC_BYTE(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .ch_data(ch_data_b), .enable(enable_b), .send_now(send_now_b),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .busy(busy_b),
        .frame_done(frame_done_b), .overrun(overrun_b), .dbg_state(dbg_state_b));

    telemetry_framer #(.NUM_CH(4), .CH_W(8), .PERIOD_CYCLES(100), .SYNC_BYTE(8'hA5)) dut_c (
        .clk(clk), .rst(rst), .ch_data(ch_data_c), .enable(enable_c), .send_now(send_now_c),
        .tx_data(tx_data_c), .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .busy(busy_c),
        .frame_done(frame_done_c), .overrun(overrun_c), .dbg_state(dbg_state_c));

    task automatic test_reset();
        rst = 1'b1;
        ch_data_a = '0; enable_a = 1'b0; send_now_a = 1'b0; tx_ready_a = 1'b0;
        ch_data_b = '0; enable_b = 1'b0; send_now_b = 1'b0; tx_ready_b = 1'b0;
        ch_data_c = 32'h87654321; enable_c = 1'b0; send_now_c = 1'b0; tx_ready_c = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid_a); end
        checks++; if (tx_data_a !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h exp 00", tx_data_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_a); end
        checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL rst_frame_done got %b exp 0", frame_done_a); end
        checks++; if (overrun_a !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun_a); end
        checks++; if (dbg_state_a !== 3'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", dbg_state_a); end
        checks++; if (busy_b !== 1'b0 || busy_c !== 1'b0) begin errors++; $display("FAIL rst_busy_bc got %b%b exp 00", busy_b, busy_c); end
        rst = 1'b0;
    endtask

    task automatic test_basic_frame();
        ch_data_a = 32'h44332211; tx_ready_a = 1'b1; send_now_a = 1'b1;
        exp_q = {8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send_now_a = 1'b0;
            exp_b = exp_q.pop_front();
            checks++;
            if (tx_valid_a !== 1'b1 || tx_data_a !== exp_b) begin
                errors++; $display("FAIL basic_byte%0d got v=%b %h exp v=1 %h", i, tx_valid_a, tx_data_a, exp_b);
            end
        end
        @(negedge clk);
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL basic_frame_done got %b exp 1", frame_done_a); end
        checks++; if (busy_a !== 1'b0 || tx_valid_a !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b valid=%b exp 0 0", busy_a, tx_valid_a); end
        @(negedge clk);
        checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", frame_done_a); end
    endtask

    task automatic test_width12();
        ch_data_b = 24'h123ABC; tx_ready_b = 1'b1; send_now_b = 1'b1;
        exp_q = {8'hA5, 8'h00, 8'h04, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h90};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send_now_b = 1'b0;
            exp_b = exp_q.pop_front();
            checks++;
            if (tx_valid_b !== 1'b1 || tx_data_b !== exp_b) begin
                errors++; $display("FAIL w12_byte%0d got v=%b %h exp v=1 %h", i, tx_valid_b, tx_data_b, exp_b);
            end
        end
        @(negedge clk);
        checks++; if (frame_done_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++; $display("FAIL w12_end got done=%b busy=%b exp 1 0", frame_done_b, busy_b);
        end
    endtask

    task automatic test_backpressure();
        logic       held_v;
        logic [7:0] held_d;
        int         cyc;
        held_v = 1'b0; held_d = 8'h00; cyc = 0;
        ch_data_a = 32'hDEADBEEF; tx_ready_a = 1'b0; send_now_a = 1'b1;
        exp_q = {8'hA5, 8'h01, 8'h04, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h27};
        while (exp_q.size() > 0 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            send_now_a = 1'b0;
            ch_data_a = $urandom();
            if (held_v) begin
                checks++;
                if (tx_valid_a !== 1'b1 || tx_data_a !== held_d) begin
                    errors++; $display("FAIL bp_stable got v=%b %h exp v=1 %h", tx_valid_a, tx_data_a, held_d);
                end
            end
            tx_ready_a = ($urandom_range(0, 9) < 3);
            if (tx_valid_a === 1'b1 && tx_ready_a) begin
                exp_b = exp_q.pop_front();
                checks++;
                if (tx_data_a !== exp_b) begin
                    errors++; $display("FAIL bp_byte got %h exp %h", tx_data_a, exp_b);
                end
                held_v = 1'b0;
            end else begin
                held_v = (tx_valid_a === 1'b1);
                held_d = tx_data_a;
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_timeout got %0d left exp 0", exp_q.size()); end
        exp_q.delete();
        tx_ready_a = 1'b1;
        @(negedge clk);
        checks++; if (frame_done_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++; $display("FAIL bp_end got done=%b busy=%b exp 1 0", frame_done_a, busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int ovr;
        ovr = 0;
        ch_data_a = 32'h04030201; tx_ready_a = 1'b1; send_now_a = 1'b1;
        exp_q = {8'hA5, 8'h02, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h02,
                 8'hA5, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0B};
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk);
            send_now_a = (t == 2 || t == 4 || t == 6);
            if (t == 3) ch_data_a = 32'h08070605;
            if (overrun_a === 1'b1) ovr++;
            if (t == 9) begin
                checks++;
                if (frame_done_a !== 1'b1 || tx_valid_a !== 1'b1 || tx_data_a !== 8'hA5) begin
                    errors++; $display("FAIL chain_gap got done=%b v=%b %h exp 1 1 a5", frame_done_a, tx_valid_a, tx_data_a);
                end
            end
            if (tx_valid_a === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL chain_extra got %h exp none", tx_data_a);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data_a !== exp_b) begin
                        errors++; $display("FAIL chain_byte t%0d got %h exp %h", t, tx_data_a, exp_b);
                    end
                end
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL chain_missing got %0d left exp 0", exp_q.size()); end
        exp_q.delete();
        checks++; if (ovr != 2) begin errors++; $display("FAIL chain_overrun got %0d exp 2", ovr); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL chain_idle got %b exp 0", busy_a); end
    endtask

    task automatic test_periodic();
        logic [7:0] pay_c [4];
        logic [7:0] csum_e;
        int nfr, pos, cyc, last_start;
        pay_c = '{8'h21, 8'h43, 8'h65, 8'h87};
        nfr = 0; pos = 0; cyc = 0; last_start = -1; csum_e = 8'h00;
        enable_c = 1'b1;
        while (nfr < 300 && cyc < 31000) begin
            @(negedge clk);
            cyc++;
            if (tx_valid_c === 1'b1) begin
                if (pos == 0) begin
                    exp_b = 8'hA5;
                    if (last_start >= 0) begin
                        checks++;
                        if (cyc - last_start != 100) begin
                            errors++; $display("FAIL per_interval got %0d exp 100", cyc - last_start);
                        end
                    end
                    last_start = cyc;
                end else if (pos == 1) begin
                    exp_b = nfr[7:0]; csum_e = exp_b;
                end else if (pos == 2) begin
                    exp_b = 8'h04; csum_e ^= exp_b;
                end else if (pos < 7) begin
                    exp_b = pay_c[pos-3]; csum_e ^= exp_b;
                end else begin
                    exp_b = csum_e;
                end
                checks++;
                if (tx_data_c !== exp_b) begin
                    errors++; $display("FAIL per_frame%0d_pos%0d got %h exp %h", nfr, pos, tx_data_c, exp_b);
                end
                if (pos == 7) begin pos = 0; nfr++; end
                else pos++;
            end
        end
        enable_c = 1'b0;
        checks++; if (nfr != 300) begin errors++; $display("FAIL per_count got %0d exp 300", nfr); end
    endtask

    task automatic test_reset_mid_frame();
        ch_data_a = 32'h11223344; tx_ready_a = 1'b1; send_now_a = 1'b1;
        repeat (4) begin
            @(negedge clk);
            send_now_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL mid_rst got valid=%b busy=%b exp 0 0", tx_valid_a, busy_a);
        end
        checks++; if (frame_done_a !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b exp 0", frame_done_a); end
        rst = 1'b0; send_now_a = 1'b1;
        exp_q = {8'hA5, 8'h00, 8'h04, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            send_now_a = 1'b0;
            exp_b = exp_q.pop_front();
            checks++;
            if (tx_valid_a !== 1'b1 || tx_data_a !== exp_b) begin
                errors++; $display("FAIL mid_byte%0d got v=%b %h exp v=1 %h", i, tx_valid_a, tx_data_a, exp_b);
            end
        end
        @(negedge clk);
        checks++; if (frame_done_a !== 1'b1) begin errors++; $display("FAIL mid_done got %b exp 1", frame_done_a); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_width12();
        test_backpressure();
        test_back_to_back();
        test_periodic();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
